// File: rtl/user_io_pkg.sv
// user_io_pkg: shared LED state encodings and mode constants for the user I/O shell
package user_io_pkg;
  typedef enum logic [2:0] {
    LED_IDLE      = 3'd0,
    LED_STEADY    = 3'd1,
    LED_BLINK_ON  = 3'd2,
    LED_BLINK_OFF = 3'd3,
    LED_PULSE_ON  = 3'd4,
    LED_PULSE_GAP = 3'd5
  } led_state_t;
  localparam logic [1:0] LED_MODE_OFF   = 2'd0;
  localparam logic [1:0] LED_MODE_ON    = 2'd1;
  localparam logic [1:0] LED_MODE_BLINK = 2'd2;
endpackage

// File: rtl/led_pwm.sv
// led_pwm: free-running PWM counter gating the lamp request into a registered LED drive
module led_pwm #(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lamp,
  input  logic [PWM_WIDTH-1:0] brightness,
  output logic                 led
);
  logic [PWM_WIDTH-1:0] r_pwm_cnt;
  logic                 r_led;
  // all-ones brightness forces fully on, since the compare alone tops out one step short
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pwm_cnt <= '0;
      r_led     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_led     <= lamp && ((&brightness) || (r_pwm_cnt < brightness));
    end
  end
  assign led = r_led;
endmodule

// File: rtl/user_led_driver.sv
// user_led_driver: LED mode FSM with pulse stretching, one-deep request queue and PWM output
module user_led_driver
  import user_io_pkg::*;
#(
  parameter logic [31:0] MIN_PULSE_CYCLES  = 32'h000FFFFF,
  parameter logic [31:0] BLINK_HALF_PERIOD = 32'h017D7840,
  parameter int          PWM_WIDTH         = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 pulse_req,
  input  logic [PWM_WIDTH-1:0] brightness,
  output logic                 led,
  output logic                 busy
);
  led_state_t  r_state, w_next;
  logic [31:0] r_cnt;
  logic        r_pending, w_pending, r_busy, w_lamp;
  logic        w_pulse_done, w_half_done;
  assign w_pulse_done = r_cnt == MIN_PULSE_CYCLES - 32'd1;
  assign w_half_done  = r_cnt == BLINK_HALF_PERIOD - 32'd1;
  assign w_lamp       = r_state inside {LED_STEADY, LED_BLINK_ON, LED_PULSE_ON};
  always_comb begin
    w_next    = LED_IDLE;
    w_pending = r_pending;
    case (r_state)
      LED_IDLE: begin
        w_pending = 1'b0;
        w_next    = (pulse_req || r_pending) ? LED_PULSE_ON :
                    (mode == LED_MODE_ON)    ? LED_STEADY :
                    (mode == LED_MODE_BLINK) ? LED_BLINK_ON : LED_IDLE;
      end
      LED_STEADY: begin
        w_pending = r_pending | pulse_req;
        w_next    = (pulse_req || mode != LED_MODE_ON) ? LED_IDLE : LED_STEADY;
      end
      LED_BLINK_ON, LED_BLINK_OFF: begin
        w_pending = r_pending | pulse_req;
        w_next    = (pulse_req || mode != LED_MODE_BLINK) ? LED_IDLE :
                    !w_half_done                ? r_state :
                    (r_state == LED_BLINK_ON)   ? LED_BLINK_OFF : LED_BLINK_ON;
      end
      LED_PULSE_ON: begin
        w_pending = r_pending | pulse_req;
        w_next    = w_pulse_done ? LED_PULSE_GAP : LED_PULSE_ON;
      end
      LED_PULSE_GAP: begin
        w_pending = r_pending | pulse_req;
        w_next    = w_pulse_done ? LED_IDLE : LED_PULSE_GAP;
      end
      default: w_next = LED_IDLE;
    endcase
  end
  // counter restarts on every state entry and saturates instead of wrapping
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= LED_IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state) ? '0 : (&r_cnt) ? r_cnt : r_cnt + 32'd1;
      r_pending <= w_pending;
      r_busy    <= w_next inside {LED_PULSE_ON, LED_PULSE_GAP};
    end
  end
  assign busy = r_busy;
  led_pwm #(.PWM_WIDTH(PWM_WIDTH)) u_pwm (
    .clock      (clock),
    .reset      (reset),
    .lamp       (w_lamp),
    .brightness (brightness),
    .led        (led)
  );
endmodule

// File: tb/tb_user_led_driver.sv
// tb_user_led_driver: directed checks of flash stretching, coalescing, blink, steady and PWM
module tb_user_led_driver;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       pulse_req;
  logic [7:0] brightness;
  logic       led, busy;
  int         checks = 0;
  int         failures = 0;
  always #5 clk = ~clk;
  user_led_driver #(
    .MIN_PULSE_CYCLES  (32'd4),
    .BLINK_HALF_PERIOD (32'd8),
    .PWM_WIDTH         (8)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .mode       (mode),
    .pulse_req  (pulse_req),
    .brightness (brightness),
    .led        (led),
    .busy       (busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; mode = 2'd0; pulse_req = 1'b0; brightness = 8'hFF;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (led !== 1'b0) begin failures++; $display("FAIL reset_led got=%b exp=0", led); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tick();
  endtask
  task automatic test_single_pulse();
    logic [11:0] exp_led, exp_busy;
    exp_led = 12'h01E; exp_busy = 12'h0FF;
    mode = 2'd0; brightness = 8'hFF; pulse_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      pulse_req = 1'b0;
      checks++;
      if (led !== exp_led[k]) begin failures++; $display("FAIL pulse_led k=%0d got=%b exp=%b", k, led, exp_led[k]); end
      checks++;
      if (busy !== exp_busy[k]) begin failures++; $display("FAIL pulse_busy k=%0d got=%b exp=%b", k, busy, exp_busy[k]); end
    end
  endtask
  task automatic test_blink();
    logic [31:0] exp_led;
    exp_led = 32'h01FE01FE;
    mode = 2'd2; brightness = 8'hFF;
    for (int k = 0; k < 32; k++) begin
      tick();
      checks++;
      if (led !== exp_led[k]) begin failures++; $display("FAIL blink_led k=%0d got=%b exp=%b", k, led, exp_led[k]); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL blink_busy k=%0d got=%b exp=0", k, busy); end
    end
    mode = 2'd0;
    tick(); tick(); tick();
  endtask
  task automatic test_back_to_back();
    logic [23:0] exp_led, exp_busy;
    exp_led = 24'h003C1E; exp_busy = 24'h01FEFF;
    mode = 2'd0; brightness = 8'hFF; pulse_req = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (k == 2) pulse_req = 1'b0;
      checks++;
      if (led !== exp_led[k]) begin failures++; $display("FAIL b2b_led k=%0d got=%b exp=%b", k, led, exp_led[k]); end
      checks++;
      if (busy !== exp_busy[k]) begin failures++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy, exp_busy[k]); end
    end
  endtask
  task automatic test_pwm();
    int on_cnt;
    mode = 2'd1; brightness = 8'h40;
    tick(); tick(); tick();
    on_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (led === 1'b1) on_cnt++;
    end
    checks++;
    if (on_cnt != 64) begin failures++; $display("FAIL pwm_40 got=%0d exp=64", on_cnt); end
    brightness = 8'h00;
    tick(); tick();
    on_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (led === 1'b1) on_cnt++;
    end
    checks++;
    if (on_cnt != 0) begin failures++; $display("FAIL pwm_00 got=%0d exp=0", on_cnt); end
  endtask
  task automatic test_steady_pulse();
    logic [15:0] exp_led, exp_busy;
    exp_led = 16'hF83D; exp_busy = 16'h01FE;
    mode = 2'd1; brightness = 8'hFF;
    tick(); tick(); tick();
    pulse_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      pulse_req = 1'b0;
      checks++;
      if (led !== exp_led[k]) begin failures++; $display("FAIL steady_led k=%0d got=%b exp=%b", k, led, exp_led[k]); end
      checks++;
      if (busy !== exp_busy[k]) begin failures++; $display("FAIL steady_busy k=%0d got=%b exp=%b", k, busy, exp_busy[k]); end
    end
  endtask
  task automatic test_reset_mid_flash();
    mode = 2'd0; brightness = 8'hFF;
    tick(); tick();
    pulse_req = 1'b1;
    tick(); tick();
    pulse_req = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (led !== 1'b0) begin failures++; $display("FAIL midrst_led got=%b exp=0", led); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (led !== 1'b0) begin failures++; $display("FAIL postrst_led k=%0d got=%b exp=0", k, led); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL postrst_busy k=%0d got=%b exp=0", k, busy); end
    end
  endtask
  initial begin
    test_reset();
    test_single_pulse();
    test_blink();
    test_back_to_back();
    test_pwm();
    test_steady_pulse();
    test_reset_mid_flash();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
